// File: rtl/alu_wb_sequencer.sv
// alu_wb_sequencer: execute/write-back sequencer that sits directly downstream of an 8x8 register file.
// Latency: an instruction is accepted on edge 0 and passes through READ, EXEC and WB in cycles 1-3.
//          The write commits on edge 3, and instr_ready is high again in cycle 4.
// Backpressure: instr_ready is high only in IDLE. instr_* is ignored while it is low.
// Ports:
//   clk, reset (async, active-low)
//   instr_valid/instr_ready handshake carrying op/rd/rs1/rs2/imm
//   rf_read_addr_1/2, rf_read_data_1/2 : register file read ports (combinational read)
//   rf_write_addr/data, rf_reg_write_n : register file write port (active-low enable)
//   done : one-cycle pulse in WB
//   flag_z/c/v/n : flags of the last completed instruction
module alu_wb_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write_n,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_n
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t state, state_next;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, result_q;
  logic              z_q, c_q, v_q, n_q;

  logic              accept;
  logic              capture_ops;
  logic              commit_alu;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v;
  logic [DATA_W:0]   sum, diff, shl, shr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and control decode. Outputs are purely state-based, so an
  // asynchronous reset deasserts the write enable immediately.
  always_comb begin
    instr_ready    = (state == IDLE);
    rf_reg_write_n = (state != WB);
    done           = (state == WB);
    accept         = (state == IDLE) && instr_valid;
    capture_ops    = (state == READ);
    commit_alu     = (state == EXEC);
  end

  // Read addresses come straight from the latched sources. They are stable
  // throughout READ and hold until the next acceptance.
  assign rf_read_addr_1 = rs1_q;
  assign rf_read_addr_2 = rs2_q;
  assign rf_write_addr  = rd_q;
  assign rf_write_data  = result_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign flag_n = n_q;

  // The extra MSB of sum and diff is the carry or borrow.
  // The shift vectors have one guard bit on the side that is shifted out,
  // so the last bit shifted out lands in it. That guard bit is 0 for a shift of 0.
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign shl  = {1'b0, a_q} << b_q[2:0];
  assign shr  = {a_q, 1'b0} >> b_q[2:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = diff[DATA_W];
        alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: begin
        alu_res = shl[DATA_W-1:0];
        alu_c   = shl[DATA_W];
      end
      OP_SRL: begin
        alu_res = shr[DATA_W:1];
        alu_c   = shr[0];
      end
      OP_LDI: alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        imm_q <= instr_imm;
      end
      if (capture_ops) begin
        a_q <= rf_read_data_1;
        b_q <= rf_read_data_2;
      end
      if (commit_alu) begin
        result_q <= alu_res;
        z_q      <= (alu_res == '0);
        c_q      <= alu_c;
        v_q      <= alu_v;
        n_q      <= alu_res[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// Bench for alu_wb_sequencer. It includes a behavioural 8x8 register file with a combinational read.
// Directed instructions push their hand-computed write-back into a queue.
// A monitor pops an entry on every write-enable cycle and compares it.
module tb_alu_wb_sequencer;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SLL = 3'b101, SRL = 3'b110, LDI = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready;
  logic [2:0] instr_op, instr_rd, instr_rs1, instr_rs2;
  logic [7:0] instr_imm;
  logic [2:0] rf_read_addr_1, rf_read_addr_2, rf_write_addr;
  logic [7:0] rf_read_data_1, rf_read_data_2, rf_write_data;
  logic       rf_reg_write_n, done;
  logic       flag_z, flag_c, flag_v, flag_n;

  logic [7:0] rf [8];

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
    logic [3:0] fl;   // {z, c, v, n}
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  always #5 clk = ~clk;

  alu_wb_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_rd       (instr_rd),
    .instr_rs1      (instr_rs1),
    .instr_rs2      (instr_rs2),
    .instr_imm      (instr_imm),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_data_2 (rf_read_data_2),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_reg_write_n (rf_reg_write_n),
    .done           (done),
    .flag_z         (flag_z),
    .flag_c         (flag_c),
    .flag_v         (flag_v),
    .flag_n         (flag_n)
  );

  // Register file model: combinational read, commit on the rising edge.
  assign rf_read_data_1 = rf[rf_read_addr_1];
  assign rf_read_data_2 = rf[rf_read_addr_2];
  always @(posedge clk) if (!rf_reg_write_n) rf[rf_write_addr] <= rf_write_data;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write-back cycle must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rf_reg_write_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%0d data=0x%0h required=none", rf_write_addr, rf_write_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 32'(rf_write_addr), 32'(e.rd));
          check("wb_data", 32'(rf_write_data), 32'(e.data));
          check("wb_flags_zcvn", 32'({flag_z, flag_c, flag_v, flag_n}), 32'(e.fl));
          check("wb_done", 32'(done), 32'd1);
        end
      end else if (done) begin
        check("done_without_write", 32'(done), 32'd0);
      end
    end
  end

  // Issue one instruction; with junk=1, hold instr_valid high with garbage
  // fields while the sequencer is busy.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input logic [7:0] ed,
                       input logic [3:0] ef, input bit expect_wr, input bit junk, output int acc);
    exp_t e;
    int   budget;
    budget = 0;
    acc    = -1;
    if (expect_wr) begin
      e.rd = rd; e.data = ed; e.fl = ef;
      exp_q.push_back(e);
    end
    @(negedge clk);
    while (!instr_ready && budget < 20) begin
      if (junk) begin
        instr_valid = 1'b1;
        instr_op    = LDI;
        instr_rd    = cycle[2:0];
        instr_imm   = 8'h55;
      end else begin
        instr_valid = 1'b0;
      end
      budget++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual ready=0 required ready=1 within 20 cycles");
      return;
    end
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    @(posedge clk);
    #1;
    acc = cycle;
    if (junk) begin
      instr_op  = LDI;
      instr_rd  = ~rd;
      instr_imm = 8'hA5;
    end else begin
      instr_valid = 1'b0;
    end
  endtask

  initial begin
    int t0, t1, t2, t3;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_write_n", 32'(rf_reg_write_n), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({flag_z, flag_c, flag_v, flag_n}), 32'd0);
    check("rst_raddr", 32'({rf_read_addr_1, rf_read_addr_2}), 32'd0);
    check("rst_waddr", 32'(rf_write_addr), 32'd0);
    check("rst_wdata", 32'(rf_write_data), 32'd0);
    rst_n = 1'b1;

    issue(LDI, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 4'b0000, 1, 0, t0);
    issue(LDI, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 4'b0000, 1, 0, t1);
    check("ldi_spacing", 32'(t1 - t0), 32'd4);
    issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h80, 4'b0011, 1, 0, t0);
    issue(SUB, 3'd4, 3'd2, 3'd1, 8'h00, 8'h82, 4'b0101, 1, 0, t0);
    issue(SUB, 3'd5, 3'd1, 3'd1, 8'h00, 8'h00, 4'b1000, 1, 0, t0);
    issue(LDI, 3'd6, 3'd0, 3'd0, 8'h81, 8'h81, 4'b0001, 1, 0, t0);
    issue(LDI, 3'd7, 3'd0, 3'd0, 8'h03, 8'h03, 4'b0000, 1, 0, t0);
    issue(SLL, 3'd0, 3'd6, 3'd7, 8'h00, 8'h08, 4'b0000, 1, 0, t0);
    issue(SRL, 3'd0, 3'd6, 3'd7, 8'h00, 8'h10, 4'b0000, 1, 0, t0);
    issue(SLL, 3'd0, 3'd6, 3'd6, 8'h00, 8'h02, 4'b0100, 1, 0, t0);
    issue(SRL, 3'd0, 3'd6, 3'd6, 8'h00, 8'h40, 4'b0100, 1, 0, t0);
    issue(SLL, 3'd0, 3'd6, 3'd5, 8'h00, 8'h81, 4'b0001, 1, 0, t0);
    issue(AND_, 3'd0, 3'd6, 3'd7, 8'h00, 8'h01, 4'b0000, 1, 0, t0);
    issue(OR_, 3'd0, 3'd6, 3'd7, 8'h00, 8'h83, 4'b0001, 1, 0, t0);
    issue(ADD, 3'd0, 3'd6, 3'd6, 8'h00, 8'h02, 4'b0110, 1, 0, t0);
    issue(LDI, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 4'b1000, 1, 0, t0);

    // Busy-time garbage on instr_* must be ignored; rd=rs1 and back-to-back RAW.
    issue(ADD, 3'd1, 3'd1, 3'd1, 8'h00, 8'hFE, 4'b0011, 1, 1, t1);
    check("accept_spacing_0", 32'(t1 - t0), 32'd4);
    issue(ADD, 3'd2, 3'd1, 3'd2, 8'h00, 8'hFF, 4'b0001, 1, 1, t2);
    check("accept_spacing_1", 32'(t2 - t1), 32'd4);
    issue(XOR_, 3'd0, 3'd6, 3'd6, 8'h00, 8'h00, 4'b1000, 1, 0, t3);
    check("accept_spacing_2", 32'(t3 - t2), 32'd4);

    repeat (6) @(negedge clk);
    check("rf_r0", 32'(rf[0]), 32'h00);
    check("rf_r1", 32'(rf[1]), 32'hFE);
    check("rf_r2", 32'(rf[2]), 32'hFF);
    check("rf_r3", 32'(rf[3]), 32'h80);
    check("rf_r4", 32'(rf[4]), 32'h82);
    check("rf_r5", 32'(rf[5]), 32'h00);
    check("rf_r6", 32'(rf[6]), 32'h81);
    check("rf_r7", 32'(rf[7]), 32'h03);

    // Abort ADD r3 during EXEC: no write, immediate idle outputs, flags cleared.
    issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00, 4'b0000, 0, 0, t0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_write_n", 32'(rf_reg_write_n), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_flags", 32'({flag_z, flag_c, flag_v, flag_n}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_r3_kept", 32'(rf[3]), 32'h80);

    issue(LDI, 3'd3, 3'd0, 3'd0, 8'h3C, 8'h3C, 4'b0000, 1, 0, t0);
    repeat (6) @(negedge clk);
    check("recover_r3", 32'(rf[3]), 32'h3C);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
